// File: rtl/main_mem_model.sv
// Block-granular main-memory responder for the cache refill/writeback port.
// Serves one request at a time after a fixed latency; a writeback arriving
// together with a refill is committed first so the refill sees victim data.
module main_mem_model #(
  parameter int PA_WIDTH   = 32,
  parameter int BO_WIDTH   = 6,
  parameter int MEM_WIDTH  = 512,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_rd_en,
  input  logic [PA_WIDTH-BO_WIDTH-1:0] mem_rd_addr,
  input  logic                         mem_wr_en,
  input  logic [PA_WIDTH-1:0]          mem_wr_addr,
  input  logic [MEM_WIDTH-1:0]         mem_wr_data,
  output logic [MEM_WIDTH-1:0]         mem_rd_data,
  output logic                         mem_rd_valid,
  output logic                         mem_wr_done,
  output logic                         busy
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    GUARD
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    rd_pend, rd_pend_nxt;
  logic [DEPTH_LOG2-1:0]   wr_idx, wr_idx_nxt;
  logic [DEPTH_LOG2-1:0]   rd_idx, rd_idx_nxt;
  logic [MEM_WIDTH-1:0]    wr_buf, wr_buf_nxt;
  logic                    do_commit;
  logic                    do_read;

  // Contents start zeroed at power-up; reset never clears the array.
  logic [MEM_WIDTH-1:0]    mem [DEPTH] = '{default: '0};

  // Byte-offset bits and block-address bits above the array depth alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_wr_addr[BO_WIDTH-1:0],
                              mem_wr_addr[PA_WIDTH-1:BO_WIDTH+DEPTH_LOG2],
                              mem_rd_addr[PA_WIDTH-BO_WIDTH-1:DEPTH_LOG2]};

  // Next-state, request capture and latency countdown.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_pend_nxt = rd_pend;
    wr_idx_nxt  = wr_idx;
    rd_idx_nxt  = rd_idx;
    wr_buf_nxt  = wr_buf;
    do_commit   = 1'b0;
    do_read     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_wr_en) begin
          wr_idx_nxt = mem_wr_addr[BO_WIDTH +: DEPTH_LOG2];
          wr_buf_nxt = mem_wr_data;
          if (mem_rd_en) begin
            rd_idx_nxt  = mem_rd_addr[DEPTH_LOG2-1:0];
            rd_pend_nxt = 1'b1;
          end
          cnt_nxt   = WR_LOAD;
          state_nxt = WRITE;
        end else if (mem_rd_en) begin
          rd_idx_nxt = mem_rd_addr[DEPTH_LOG2-1:0];
          cnt_nxt    = RD_LOAD;
          state_nxt  = READ;
        end
      end
      WRITE: begin
        if (cnt == '0) begin
          do_commit = 1'b1;
          if (rd_pend) begin
            rd_pend_nxt = 1'b0;
            cnt_nxt     = RD_LOAD;
            state_nxt   = READ;
          end else begin
            state_nxt = GUARD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      READ: begin
        if (cnt == '0) begin
          do_read   = 1'b1;
          state_nxt = GUARD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GUARD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control/datapath registers and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_pend      <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      wr_buf       <= '0;
      mem_rd_data  <= '0;
      mem_rd_valid <= 1'b0;
      mem_wr_done  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rd_pend      <= rd_pend_nxt;
      wr_idx       <= wr_idx_nxt;
      rd_idx       <= rd_idx_nxt;
      wr_buf       <= wr_buf_nxt;
      mem_rd_valid <= do_read;
      mem_wr_done  <= do_commit;
      if (do_read) begin
        mem_rd_data <= mem[rd_idx];
      end
      // busy lags the state by one cycle: rises the cycle after acceptance
      // and stays up through the cycle following GUARD.
      busy         <= (state != IDLE);
    end
  end

  // Array write; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (do_commit && !rst) begin
      mem[wr_idx] <= wr_buf;
    end
  end

endmodule

// File: tb/tb_main_mem_model.sv
// Directed self-checking bench for main_mem_model with default latencies (4/4).
module tb_main_mem_model;

  localparam int PA_W = 32;
  localparam int BO_W = 6;
  localparam int MW   = 512;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mem_rd_en;
  logic [PA_W-BO_W-1:0] mem_rd_addr;
  logic                 mem_wr_en;
  logic [PA_W-1:0]      mem_wr_addr;
  logic [MW-1:0]        mem_wr_data;
  logic [MW-1:0]        mem_rd_data;
  logic                 mem_rd_valid;
  logic                 mem_wr_done;
  logic                 busy;

  main_mem_model #(
    .PA_WIDTH  (PA_W),
    .BO_WIDTH  (BO_W),
    .MEM_WIDTH (MW),
    .DEPTH_LOG2(10),
    .RD_LAT    (4),
    .WR_LAT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_wr_done (mem_wr_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  localparam logic [MW-1:0] PAT_D = {16{32'hDEADBEEF}};
  localparam logic [MW-1:0] PAT_A = {8{64'hA5A5_0000_1111_2222}};
  localparam logic [MW-1:0] PAT_B = {16{32'hBAD0_0BAD}};
  localparam logic [MW-1:0] PAT_C = {16{32'hC0FF_EE00}};

  // Cycle k is the interval following the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  int            wr_cnt   = 0;
  int            rd_cnt   = 0;
  int            both_cnt = 0;
  int            wr_cyc   = -1;
  int            rd_cyc   = -1;
  logic [MW-1:0] rd_dat   = '0;
  always @(negedge clk) begin
    if (mem_wr_done) begin
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
    end
    if (mem_rd_valid) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc = cyc;
      rd_dat = mem_rd_data;
    end
    if (mem_wr_done && mem_rd_valid) both_cnt = both_cnt + 1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int t0, wr_base, rd_base;
  logic b5, b6;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one request for a single edge (t0), then drop the levels.
  task automatic issue(input logic wr, input logic [PA_W-1:0] wa, input logic [MW-1:0] wd,
                       input logic rd, input logic [PA_W-BO_W-1:0] ra);
    wr_base     = wr_cnt;
    rd_base     = rd_cnt;
    mem_wr_en   = wr;
    mem_wr_addr = wa;
    mem_wr_data = wd;
    mem_rd_en   = rd;
    mem_rd_addr = ra;
    t0 = cyc + 1;
    tick();
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    mem_rd_en   = 1'b1;
    mem_rd_addr = 26'h5;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    repeat (3) tick();
    check("rst_rd_data", mem_rd_data, '0);
    check("rst_rd_valid", MW'(mem_rd_valid), MW'(0));
    check("rst_wr_done", MW'(mem_wr_done), MW'(0));
    check("rst_busy", MW'(busy), MW'(0));
    check("rst_no_pulses", MW'(wr_cnt + rd_cnt), MW'(0));

    // First post-reset edge accepts the held read of block 0x5.
    rst = 1'b0;
    issue(1'b0, '0, '0, 1'b1, 26'h5);
    check("busy_lag", MW'(busy), MW'(0));
    tick();
    check("busy_up", MW'(busy), MW'(1));
    repeat (10) tick();
    check("rd5_count", MW'(rd_cnt - rd_base), MW'(1));
    check("rd5_cycle", MW'(rd_cyc), MW'(t0 + 4));
    check("rd5_data", rd_dat, '0);

    // Writeback of block 0x12 (offset bits set, must be ignored).
    issue(1'b1, 32'h0000_04BF, PAT_D, 1'b0, '0);
    b5 = 1'bx;
    b6 = 1'bx;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cyc == t0 + 5) b5 = busy;
      if (cyc == t0 + 6) b6 = busy;
    end
    check("wr12_count", MW'(wr_cnt - wr_base), MW'(1));
    check("wr12_cycle", MW'(wr_cyc), MW'(t0 + 4));
    check("wr12_no_rd", MW'(rd_cnt - rd_base), MW'(0));
    check("wr12_busy_t5", MW'(b5), MW'(1));
    check("wr12_busy_t6", MW'(b6), MW'(0));

    issue(1'b0, '0, '0, 1'b1, 26'h12);
    repeat (10) tick();
    check("rd12_count", MW'(rd_cnt - rd_base), MW'(1));
    check("rd12_cycle", MW'(rd_cyc), MW'(t0 + 4));
    check("rd12_data", rd_dat, PAT_D);
    check("rd12_held", mem_rd_data, PAT_D);

    // Combined write+read of block 0x40: write first, read sees new data.
    issue(1'b1, 32'h0000_1000, PAT_A, 1'b1, 26'h40);
    repeat (14) tick();
    check("comb_wr_count", MW'(wr_cnt - wr_base), MW'(1));
    check("comb_wr_cycle", MW'(wr_cyc), MW'(t0 + 4));
    check("comb_rd_count", MW'(rd_cnt - rd_base), MW'(1));
    check("comb_rd_cycle", MW'(rd_cyc), MW'(t0 + 8));
    check("comb_rd_data", rd_dat, PAT_A);

    // Second read raised during READ and held: accepted only after GUARD.
    issue(1'b0, '0, '0, 1'b1, 26'h12);
    tick();
    tick();
    mem_rd_en   = 1'b1;
    mem_rd_addr = 26'h40;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cyc == t0 + 4) begin
        check("held_first_valid", MW'(mem_rd_valid), MW'(1));
        check("held_first_data", mem_rd_data, PAT_D);
      end
      if (rd_cnt - rd_base >= 2) mem_rd_en = 1'b0;
    end
    mem_rd_en = 1'b0;
    check("held_rd_count", MW'(rd_cnt - rd_base), MW'(2));
    check("held_second_cycle", MW'(rd_cyc), MW'(t0 + 10));
    check("held_second_data", rd_dat, PAT_A);

    // Reset on the commit edge: no done pulse, block keeps old contents.
    issue(1'b1, 32'h0000_0480, PAT_B, 1'b0, '0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("abort_no_done", MW'(wr_cnt - wr_base), MW'(0));
    check("abort_busy", MW'(busy), MW'(0));
    check("abort_rd_data_clr", mem_rd_data, '0);
    issue(1'b0, '0, '0, 1'b1, 26'h12);
    repeat (10) tick();
    check("abort_rd_count", MW'(rd_cnt - rd_base), MW'(1));
    check("abort_rd_data", rd_dat, PAT_D);

    // Aliasing: block 0x400 maps onto block 0x000.
    issue(1'b1, 32'h0001_0000, PAT_C, 1'b0, '0);
    repeat (10) tick();
    check("alias_wr_count", MW'(wr_cnt - wr_base), MW'(1));
    issue(1'b0, '0, '0, 1'b1, 26'h000);
    repeat (10) tick();
    check("alias_rd_cycle", MW'(rd_cyc), MW'(t0 + 4));
    check("alias_rd_data", rd_dat, PAT_C);

    check("no_overlap", MW'(both_cnt), MW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
